// File: rtl/ihad_pkg.sv
// Shared widths, FSM state type and the round/clip helper for the inverse 4x4 Hadamard block.
package ihad_pkg;

    localparam int DEF_COEF_W = 16;
    localparam int DEF_RES_W  = 9;

    // Working width for rounding/clipping; must exceed COEF_W+4.
    localparam int SR_W = 40;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [SR_W-1:0] res;
        logic                   sat;
    } sat_res_t;

    function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] v, input int res_w);
        logic signed [SR_W-1:0] r;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        sat_res_t               o;
        // Divide by 16 with ties going toward +inf.
        r     = (v + SR_W'(8)) >>> 4;
        hi    = (SR_W'(1) <<< (res_w - 1)) - SR_W'(1);
        lo    = -hi - SR_W'(1);
        o.sat = (r > hi) || (r < lo);
        o.res = (r > hi) ? hi : ((r < lo) ? lo : r);
        return o;
    endfunction

endpackage

// File: rtl/ihadamard4x4_if.sv
// Row-in / column-out stream bundle of the inverse 4x4 Hadamard block.
// Both streams use valid/ready: a beat transfers on a rising edge where valid && ready;
// the source holds valid and payload stable until that beat, and ready may depend on state only.
interface ihadamard4x4_if #(
    parameter int COEF_W = ihad_pkg::DEF_COEF_W,
    parameter int RES_W  = ihad_pkg::DEF_RES_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4*COEF_W-1:0]  in_coef;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*RES_W-1:0]   out_res;
    logic [1:0]           out_col;
    logic                 out_last;
    logic                 out_sat;

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_res, out_col, out_last, out_sat
    );

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_res, out_col, out_last, out_sat
    );
endinterface

// File: rtl/hadamard_bfly4.sv
// Combinational 4-point Hadamard butterfly; output lanes grow by two bits.
module hadamard_bfly4 #(
    parameter int W = 16
) (
    input  logic [4*W-1:0]     x_i,
    output logic [4*(W+2)-1:0] y_o
);
    logic signed [W-1:0] x0, x1, x2, x3;
    logic signed [W:0]   a, b, d, e;
    logic signed [W+1:0] t0, t1, t2, t3;

    assign x0 = x_i[0*W +: W];
    assign x1 = x_i[1*W +: W];
    assign x2 = x_i[2*W +: W];
    assign x3 = x_i[3*W +: W];

    assign a = {x0[W-1], x0} + {x3[W-1], x3};
    assign b = {x1[W-1], x1} + {x2[W-1], x2};
    assign d = {x1[W-1], x1} - {x2[W-1], x2};
    assign e = {x0[W-1], x0} - {x3[W-1], x3};

    assign t0 = {a[W], a} + {b[W], b};
    assign t1 = {d[W], d} + {e[W], e};
    assign t2 = {a[W], a} - {b[W], b};
    assign t3 = {e[W], e} - {d[W], d};

    assign y_o = {t3, t2, t1, t0};
endmodule

// File: rtl/ihadamard4x4.sv
// Inverse 4x4 Hadamard: row butterfly into a transpose buffer, column butterfly, /16 round and clip.
// Optional macro IHAD_PINGPONG_EN: two transpose banks so loading and draining overlap.
module ihadamard4x4
    import ihad_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int RES_W  = DEF_RES_W
) (
    input  logic          clk,
    input  logic          rst,
    ihadamard4x4_if.slave bus,
    output state_t        dbg_state_o
);
    localparam int HW = COEF_W + 2;
    localparam int VW = COEF_W + 4;
`ifdef IHAD_PINGPONG_EN
    localparam logic PP_EN = 1'b1;
`else
    localparam logic PP_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [1:0] wr_row_q, wr_row_d;
    logic [1:0] rd_col_q, rd_col_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;

    // Bank 1 is only ever addressed when the ping-pong build toggles the bank pointers.
    logic [HW-1:0] buf_q [2][4][4];

    logic               in_beat, out_beat, out_valid;
    logic [4*HW-1:0]    h_t, v_in;
    logic [4*VW-1:0]    v_w;
    logic [4*RES_W-1:0] res_w;
    logic [3:0]         sat_w;

    assign out_valid    = (state_q == S_DRAIN);
    assign bus.in_ready = !rst && !full_q[wr_bank_q];
    assign in_beat      = bus.in_valid && bus.in_ready;
    assign out_beat     = out_valid && bus.out_ready;

    hadamard_bfly4 #(.W(COEF_W)) u_hbfly (.x_i(bus.in_coef), .y_o(h_t));

    always_comb begin
        v_in = '0;
        for (int k = 0; k < 4; k++) begin
            v_in[k*HW +: HW] = buf_q[rd_bank_q][2'(k)][rd_col_q];
        end
    end

    hadamard_bfly4 #(.W(HW)) u_vbfly (.x_i(v_in), .y_o(v_w));

    for (genvar k = 0; k < 4; k++) begin : g_lane
        sat_res_t sr;
        logic     unused_hi;
        assign sr = sat_round({{(SR_W-VW){v_w[k*VW+VW-1]}}, v_w[k*VW +: VW]}, RES_W);
        assign res_w[k*RES_W +: RES_W] = sr.res[RES_W-1:0];
        assign sat_w[k]                = sr.sat;
        assign unused_hi               = ^sr.res[SR_W-1:RES_W];
    end

    always_comb begin
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (in_beat) begin
            wr_row_d = wr_row_q + 2'd1;
            if (wr_row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = wr_bank_q ^ PP_EN;
            end
        end
        if (out_beat) begin
            rd_col_d = rd_col_q + 2'd1;
            if (rd_col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = rd_bank_q ^ PP_EN;
            end
        end
        // The output side drains whenever the bank it points at holds a complete block.
        state_d = full_d[rd_bank_d] ? S_DRAIN : S_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            wr_row_q  <= 2'd0;
            rd_col_q  <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_beat) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[wr_bank_q][wr_row_q][k] <= h_t[k*HW +: HW];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_res   = out_valid ? res_w : '0;
    assign bus.out_col   = rd_col_q;
    assign bus.out_last  = out_valid && (rd_col_q == 2'd3);
    assign bus.out_sat   = out_valid && (|sat_w);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ihadamard4x4.sv
// Directed bench for ihadamard4x4: DC, round trip, rounding/clipping, lane order, backpressure, reset, throughput.
module tb_ihadamard4x4;
    import ihad_pkg::*;

    localparam int W = 40;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic last_ov;
    int w, tp_gap, tp_bubble, tmp;

    ihadamard4x4_if bus ();

    ihadamard4x4 dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    function automatic logic [63:0] row(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    // Expected beat word: {lane3..lane0, col, last, sat}.
    function automatic logic [W-1:0] mk(input int l0, input int l1, input int l2, input int l3,
                                        input int col, input bit sat);
        logic [35:0] r;
        r = {9'(l3), 9'(l2), 9'(l1), 9'(l0)};
        return {r, 2'(col), (col == 3), sat};
    endfunction

    function automatic logic [W-1:0] outw();
        return {bus.out_res, bus.out_col, bus.out_last, bus.out_sat};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_uniform(input int v, input bit sat);
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(v, v, v, v, c, sat));
    endtask

    task automatic send_row(input logic [63:0] coef, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_coef  = coef;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("in_accept", W'(bus.in_ready), W'(1));
        last_ov = bus.out_valid;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] r0, input logic [63:0] r1,
                              input logic [63:0] r2, input logic [63:0] r3, output int first_wait);
        int wt;
        send_row(r0, first_wait);
        send_row(r1, wt);
        send_row(r2, wt);
        send_row(r3, wt);
    endtask

    task automatic recv_beat(input string tag, output int waited);
        logic [W-1:0] exp;
        waited = 0;
        @(negedge clk);
        while (!(bus.out_valid === 1'b1 && bus.out_ready === 1'b1) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, W'(bus.out_valid), W'(1));
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        chk(tag, outw(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic recv4(input string tag);
        int wt;
        for (int i = 0; i < 4; i++) recv_beat(tag, wt);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", W'(bus.in_ready), W'(0));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_out_word", outw(), '0);
        chk("rst_state", W'(dbg_state), W'(S_LOAD));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
        @(posedge clk);
        #1;

        // DC block and first-beat latency
        push_uniform(1, 1'b0);
        send_block(row(16, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        chk("dc_pre_valid", W'(last_ov), W'(0));
        recv_beat("dc", w);
        chk("dc_latency", W'(w), W'(0));
        for (int i = 0; i < 3; i++) recv_beat("dc", w);
        @(negedge clk);
        chk("dc_idle", W'(bus.out_valid), W'(0));
        @(posedge clk);
        #1;

        // Round trip of a constant-5 block
        push_uniform(5, 1'b0);
        send_block(row(80, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("roundtrip");

        // Rounding and saturation
        push_uniform(-1, 1'b0);
        send_block(row(-24, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("round_neg24");
        push_uniform(0, 1'b0);
        send_block(row(-8, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("round_tie_neg8");
        push_uniform(255, 1'b1);
        send_block(row(32767, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("sat_pos");
        push_uniform(-256, 1'b1);
        send_block(row(-32768, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("sat_neg");

        // Lane order through both butterflies
        exp_q.push_back(mk(4, 4, 2, 2, 0, 1'b0));
        exp_q.push_back(mk(4, 4, 2, 2, 1, 1'b0));
        exp_q.push_back(mk(2, 2, 0, 0, 2, 1'b0));
        exp_q.push_back(mk(2, 2, 0, 0, 3, 1'b0));
        send_block(row(32, 16, 0, 0), row(16, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("mixed");
        exp_q.push_back(mk(1, 1, 1, 1, 0, 1'b0));
        exp_q.push_back(mk(-1, -1, -1, -1, 1, 1'b0));
        exp_q.push_back(mk(1, 1, 1, 1, 2, 1'b0));
        exp_q.push_back(mk(-1, -1, -1, -1, 3, 1'b0));
        send_block(row(0, 0, 0, 16), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv4("lane3");

        // Backpressure held on column 1
        push_uniform(1, 1'b0);
        send_block(row(16, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        recv_beat("bp", w);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", W'(bus.out_valid), W'(1));
            chk("bp_hold", outw(), exp_q[0]);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) recv_beat("bp", w);

        // Reset in the middle of loading
        send_row(row(100, -7, 3, 9), w);
        send_row(row(-5, 0, 44, 1), w);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", W'(bus.out_valid), W'(0));
        @(posedge clk);
        #1;
        push_uniform(1, 1'b0);
        send_block(row(16, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
        chk("mid_rst_pre_valid", W'(last_ov), W'(0));
        recv_beat("mid_rst", w);
        chk("mid_rst_latency", W'(w), W'(0));
        for (int i = 0; i < 3; i++) recv_beat("mid_rst", w);

        // Two back-to-back blocks
        push_uniform(1, 1'b0);
        push_uniform(5, 1'b0);
        fork
            begin
                send_block(row(16, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tmp);
                send_block(row(80, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), row(0, 0, 0, 0), tp_gap);
            end
            begin
                int wt;
                for (int i = 0; i < 4; i++) recv_beat("tp_a", wt);
                recv_beat("tp_b", tp_bubble);
                for (int i = 0; i < 3; i++) recv_beat("tp_b", wt);
            end
        join
`ifdef IHAD_PINGPONG_EN
        chk("tp_no_gap", W'(tp_gap), W'(0));
        chk("tp_no_bubble", W'(tp_bubble), W'(0));
`else
        chk("tp_gap_ge4", W'(tp_gap >= 4), W'(1));
`endif

        chk("exp_q_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
